// File: rtl/md_issue_ctrl_pkg.sv
// Shared encodings and defaults for the multiply/divide issue controller.
// Command, unit-op and controller-state types live here.
package md_issue_ctrl_pkg;

  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 9;
  localparam int CNT_W       = 4;

  typedef enum logic [3:0] {
    CMD_NONE  = 4'd0,
    CMD_MULTU = 4'd1,
    CMD_MULT  = 4'd2,
    CMD_DIVU  = 4'd3,
    CMD_DIV   = 4'd4,
    CMD_MFHI  = 4'd5,
    CMD_MFLO  = 4'd6,
    CMD_MTHI  = 4'd7,
    CMD_MTLO  = 4'd8
  } md_cmd_e;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2
  } md_state_e;

  function automatic md_op_e cmd2op(
    input md_cmd_e c
  );
    md_op_e op;
    case (c)
      CMD_MULT: op = OP_MULT;
      CMD_DIVU: op = OP_DIVU;
      CMD_DIV:  op = OP_DIV;
      default:  op = OP_MULTU;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/md_issue_ctrl_lat_counter.sv
// Latency countdown: load, decrement while nonzero,
// and flags for "at zero" and "reaches zero this edge".
module md_lat_counter
  import md_issue_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);
  assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage issue/stall control for the multiply/divide unit.
// Holds MD commands while a prior op is in flight.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic        e_flush,
  input  logic [3:0]  e_cmd,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic        md_start,
  output logic [1:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic [31:0] md_wd,
  output logic        md_mthi,
  output logic        md_mtlo,
  output logic        stall,
  output logic [31:0] mf_data,
  output logic        mf_valid,
  output logic [15:0] stall_cnt
);

  md_state_e        r_state;
  md_state_e        w_next;
  md_cmd_e          w_cmd;
  logic             w_md_class;
  logic             w_stall;
  logic             w_go;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_dec;
  logic             w_zero;
  logic             w_last;
  logic             w_done;
  logic [15:0]      r_stall_cnt;

  assign w_cmd = md_cmd_e'(e_cmd);

  assign w_is_mul = (w_cmd == CMD_MULT)
                  | (w_cmd == CMD_MULTU);
  assign w_is_div = (w_cmd == CMD_DIV)
                  | (w_cmd == CMD_DIVU);

  // Reset masks the command so every strobe is quiet.
  assign w_md_class = reset & e_valid & ~e_flush
                    & (w_cmd != CMD_NONE);

  assign w_stall = w_md_class
                 & ((r_state != ST_IDLE) | md_busy);
  assign w_go    = w_md_class & ~w_stall;
  assign stall   = w_stall;

  assign md_a  = rs_val;
  assign md_b  = rt_val;
  assign md_wd = rs_val;

  // Leave WAIT on the edge the count reaches zero,
  // but only once the unit itself is idle.
  assign w_done = w_zero | w_last;
  assign w_dec  = (r_state != ST_IDLE);

  md_lat_counter u_cnt (
    .clk        (clk),
    .i_rst_n    (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero),
    .o_last     (w_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_go && w_is_mul) begin
          w_next     = ST_MUL_WAIT;
          w_load     = 1'b1;
          w_load_val = CNT_W'(MUL_LAT);
        end else if (w_go && w_is_div) begin
          w_next     = ST_DIV_WAIT;
          w_load     = 1'b1;
          w_load_val = CNT_W'(DIV_LAT);
        end
      end
      ST_MUL_WAIT,
      ST_DIV_WAIT: begin
        if (w_done && !md_busy) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    md_start = 1'b0;
    md_op    = OP_MULTU;
    md_mthi  = 1'b0;
    md_mtlo  = 1'b0;
    mf_valid = 1'b0;
    mf_data  = '0;
    if (w_go) begin
      unique case (1'b1)
        w_is_mul,
        w_is_div: begin
          md_start = 1'b1;
          md_op    = cmd2op(w_cmd);
        end
        (w_cmd == CMD_MTHI): md_mthi = 1'b1;
        (w_cmd == CMD_MTLO): md_mtlo = 1'b1;
        (w_cmd == CMD_MFHI): begin
          mf_valid = 1'b1;
          mf_data  = md_hi;
        end
        (w_cmd == CMD_MFLO): begin
          mf_valid = 1'b1;
          mf_data  = md_lo;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a behavioural
// multiply/divide unit supplying HI/LO.
module tb_md_issue_ctrl;
  import md_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_valid;
  logic        e_flush;
  logic [3:0]  e_cmd;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_busy;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic        md_start;
  logic [1:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [31:0] md_wd;
  logic        md_mthi;
  logic        md_mtlo;
  logic        stall;
  logic [31:0] mf_data;
  logic        mf_valid;
  logic [15:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;
  int n;
  int n2;
  int s0;

  always #5 clk = ~clk;

  md_issue_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .e_valid   (e_valid),
    .e_flush   (e_flush),
    .e_cmd     (e_cmd),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .md_busy   (md_busy),
    .md_hi     (md_hi),
    .md_lo     (md_lo),
    .md_start  (md_start),
    .md_op     (md_op),
    .md_a      (md_a),
    .md_b      (md_b),
    .md_wd     (md_wd),
    .md_mthi   (md_mthi),
    .md_mtlo   (md_mtlo),
    .stall     (stall),
    .mf_data   (mf_data),
    .mf_valid  (mf_valid),
    .stall_cnt (stall_cnt)
  );

  // Behavioural unit: results land at the start edge.
  always @(posedge clk) begin
    if (md_start) begin
      case (md_op)
        2'b00: {md_hi, md_lo} <= {32'd0, md_a} * {32'd0, md_b};
        2'b01: {md_hi, md_lo} <= 64'($signed(md_a) * $signed(md_b));
        2'b10: begin
          md_lo <= (md_b != 0) ? md_a / md_b : '1;
          md_hi <= (md_b != 0) ? md_a % md_b : md_a;
        end
        default: begin
          md_lo <= (md_b != 0) ? 32'($signed(md_a) / $signed(md_b)) : '1;
          md_hi <= (md_b != 0) ? 32'($signed(md_a) % $signed(md_b)) : md_a;
        end
      endcase
    end else if (md_mthi) begin
      md_hi <= md_wd;
    end else if (md_mtlo) begin
      md_lo <= md_wd;
    end
  end

  always @(posedge clk) begin
    if (reset && md_start) n_start++;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Strobes must be exclusive and silent while stalled or flushed.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("excl",
          32'((32'(md_start) + 32'(md_mthi) + 32'(md_mtlo) > 1)
           || ((md_start | md_mthi | md_mtlo) && (stall | e_flush))),
          32'd0);
    end
  end

  task automatic apply(
    input logic        f,
    input logic [3:0]  c,
    input logic [31:0] a,
    input logic [31:0] b
  );
    @(posedge clk);
    #1;
    e_valid = (c != CMD_NONE);
    e_flush = f;
    e_cmd   = c;
    rs_val  = a;
    rt_val  = b;
  endtask

  task automatic wait_stall(output int k);
    k = 0;
    @(negedge clk);
    while (stall && k < 40) begin
      k++;
      @(negedge clk);
    end
    if (k >= 40) chk("stall_timeout", 32'(k), 32'd0);
  endtask

  initial begin
    reset   = 1'b0;
    e_valid = 1'b1;
    e_flush = 1'b0;
    e_cmd   = CMD_MULT;
    rs_val  = 32'd5;
    rt_val  = 32'd6;
    md_busy = 1'b0;
    md_hi   = '0;
    md_lo   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_start", 32'(md_start), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mfv", 32'(mf_valid), 32'd0);
    chk("rst_scnt", 32'(stall_cnt), 32'd0);
    e_cmd = CMD_MFHI;
    #1;
    chk("rst_mfd", mf_data, 32'd0);
    chk("rst_mfv2", 32'(mf_valid), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    e_valid = 1'b0;
    e_cmd   = CMD_NONE;

    // MULT 7 * -3, then MFLO
    apply(1'b0, CMD_MULT, 32'd7, 32'hFFFF_FFFD);
    @(negedge clk);
    chk("mult_start", 32'(md_start), 32'd1);
    chk("mult_op", 32'(md_op), 32'd1);
    chk("mult_a", md_a, 32'd7);
    chk("mult_b", md_b, 32'hFFFF_FFFD);
    apply(1'b0, CMD_MFLO, 32'd0, 32'd0);
    @(negedge clk);
    chk("mflo_held_mfv", 32'(mf_valid), 32'd0);
    chk("mflo_held_mfd", mf_data, 32'd0);
    wait_stall(n);
    chk("mult_stalls", 32'(n + 1), 32'd4);
    chk("mflo_mfv", 32'(mf_valid), 32'd1);
    chk("mflo_data", mf_data, 32'hFFFF_FFEB);
    chk("mult_scnt", 32'(stall_cnt), 32'd4);

    // DIVU 100 / 7, MFHI then MFLO
    apply(1'b0, CMD_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    chk("divu_start", 32'(md_start), 32'd1);
    chk("divu_op", 32'(md_op), 32'd2);
    apply(1'b0, CMD_MFHI, 32'd0, 32'd0);
    wait_stall(n);
    chk("divu_stalls", 32'(n), 32'd9);
    chk("mfhi_data", mf_data, 32'd2);
    apply(1'b0, CMD_MFLO, 32'd0, 32'd0);
    @(negedge clk);
    chk("mflo2_stall", 32'(stall), 32'd0);
    chk("mflo2_data", mf_data, 32'd14);
    chk("divu_scnt", 32'(stall_cnt), 32'd13);

    // MULTU then DIV back to back
    s0 = n_start;
    apply(1'b0, CMD_MULTU, 32'd3, 32'd5);
    apply(1'b0, CMD_DIV, 32'hFFFF_FFEC, 32'd3);
    wait_stall(n);
    chk("div_held", 32'(n), 32'd4);
    chk("div_start", 32'(md_start), 32'd1);
    chk("div_op", 32'(md_op), 32'd3);
    apply(1'b0, CMD_MFLO, 32'd0, 32'd0);
    wait_stall(n);
    chk("div_stalls", 32'(n), 32'd9);
    chk("div_lo", mf_data, 32'hFFFF_FFFA);
    chk("b2b_starts", 32'(n_start - s0), 32'd2);
    chk("b2b_scnt", 32'(stall_cnt), 32'd26);

    // MTHI then MFHI
    apply(1'b0, CMD_MTHI, 32'h1234, 32'd0);
    @(negedge clk);
    chk("mthi_pulse", 32'(md_mthi), 32'd1);
    chk("mthi_lo", 32'(md_mtlo), 32'd0);
    chk("mthi_wd", md_wd, 32'h1234);
    apply(1'b0, CMD_MFHI, 32'd0, 32'd0);
    @(negedge clk);
    chk("mthi_once", 32'(md_mthi), 32'd0);
    chk("mfhi_1234", mf_data, 32'h1234);

    // Reset three cycles into DIV_WAIT
    apply(1'b0, CMD_DIV, 32'd50, 32'd5);
    apply(1'b0, CMD_MFHI, 32'd0, 32'd0);
    apply(1'b0, CMD_MFHI, 32'd0, 32'd0);
    apply(1'b0, CMD_MFHI, 32'd0, 32'd0);
    @(negedge clk);
    chk("pre_rst_stall", 32'(stall), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("in_rst_stall", 32'(stall), 32'd0);
    chk("in_rst_mfd", mf_data, 32'd0);
    s0 = n_start;
    apply(1'b0, CMD_MULT, 32'd2, 32'd3);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", 32'(stall), 32'd0);
    chk("post_rst_start", 32'(md_start), 32'd1);
    chk("post_rst_scnt", 32'(stall_cnt), 32'd0);
    apply(1'b0, CMD_MFLO, 32'd0, 32'd0);
    wait_stall(n);
    chk("post_rst_lo", mf_data, 32'd6);

    // Flushed DIV
    s0 = n_start;
    apply(1'b1, CMD_DIV, 32'd9, 32'd2);
    @(negedge clk);
    chk("flush_start", 32'(md_start), 32'd0);
    chk("flush_stall", 32'(stall), 32'd0);
    apply(1'b0, CMD_MFHI, 32'd0, 32'd0);
    @(negedge clk);
    chk("flush_idle", 32'(stall), 32'd0);
    chk("flush_hi", mf_data, 32'd0);
    chk("flush_nstart", 32'(n_start - s0), 32'd0);

    // Slow unit keeps WAIT past the count
    apply(1'b0, CMD_MULT, 32'd4, 32'd5);
    apply(1'b0, CMD_MFLO, 32'd0, 32'd0);
    md_busy = 1'b1;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (stall) n++;
    end
    @(posedge clk);
    #1 md_busy = 1'b0;
    wait_stall(n2);
    chk("slow_stalls", 32'(n + n2), 32'd8);
    chk("slow_lo", mf_data, 32'd20);

    apply(1'b0, CMD_NONE, 32'd0, 32'd0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want done");
    $fatal(1);
  end

endmodule

// File: doc/md_issue_ctrl.md
MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 The block SHALL have a parameter MUL_LAT, default 4: busy cycles the multiply/divide unit reports after a multiply start.
REQ-002 The block SHALL have a parameter DIV_LAT, default 9: busy cycles the multiply/divide unit reports after a divide start.
REQ-003 The block SHALL have port clk, in, 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, in, 1: synchronous, active-low reset.
REQ-005 The block SHALL have port e_valid, in, 1: E-stage instruction valid.
REQ-006 The block SHALL have port e_flush, in, 1: E-stage instruction is being killed this cycle.
REQ-007 The block SHALL have port e_cmd, in, 4: decoded MD command (NONE, MULTU, MULT, DIVU, DIV, MFHI, MFLO, MTHI, MTLO).
REQ-008 The block SHALL have ports rs_val and rt_val, in, 32 each: forwarded E-stage operands.
REQ-009 The block SHALL have ports md_busy, in, 1, and md_hi, md_lo, in, 32 each: status and results from the unit.
REQ-010 The block SHALL have port md_start, out, 1: one-cycle start pulse to the unit.
REQ-011 The block SHALL have port md_op, out, 2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-012 The block SHALL have ports md_a, md_b and md_wd, out, 32 each: md_a=rs_val, md_b=rt_val, md_wd=rs_val.
REQ-013 The block SHALL have ports md_mthi and md_mtlo, out, 1 each: one-cycle HI/LO write strobes.
REQ-014 The block SHALL have port stall, out, 1: freeze F/D/E; the E instruction is held.
REQ-015 The block SHALL have ports mf_data, out, 32, and mf_valid, out, 1: MFHI/MFLO result to the E-stage writeback mux.
REQ-016 The block SHALL have port stall_cnt, out, 16: saturating count of MD stall cycles.

Function
REQ-017 The block SHALL implement states IDLE, MUL_WAIT and DIV_WAIT plus a 4-bit countdown cnt.
REQ-018 A cmd SHALL be "MD-class" when e_valid=1, e_flush=0 and e_cmd != NONE.
REQ-019 stall SHALL be 1 iff the cmd is MD-class and (state != IDLE or md_busy=1); stall is combinational.
REQ-020 Issue SHALL occur when an MD-class MULT/MULTU/DIV/DIVU is present and stall=0: md_start=1 and md_op is encoded in the same cycle.
REQ-021 On issue, the next state SHALL be MUL_WAIT with cnt=MUL_LAT for multiplies, or DIV_WAIT with cnt=DIV_LAT for divides.
REQ-022 In either WAIT state, cnt SHALL decrement each cycle while nonzero.
REQ-023 The block SHALL return to IDLE on the first edge where cnt=0 and md_busy=0; it stays in WAIT while md_busy=1 even if cnt=0, to tolerate a slower unit.
REQ-024 MTHI/MTLO with stall=0 SHALL pulse md_mthi or md_mtlo for one cycle; the state is unchanged.
REQ-025 MFHI/MFLO with stall=0 SHALL drive mf_valid=1 with mf_data=md_hi or md_lo; otherwise mf_valid=0 and mf_data=0.
REQ-026 md_start, md_mthi and md_mtlo SHALL never assert while stall=1, while e_flush=1, or in the same cycle as each other.
REQ-027 A held instruction SHALL issue in the first cycle stall drops, exactly once.
REQ-028 stall_cnt SHALL increment on every cycle with stall=1 and saturate at 16'hFFFF.

Reset
REQ-029 With reset=0 at an edge, the block SHALL set state=IDLE, cnt=0 and stall_cnt=0, including mid-WAIT; the unit shares the same reset.
REQ-030 During reset, md_start, md_mthi, md_mtlo, mf_valid and stall SHALL be 0, and mf_data SHALL be 0.

Structure
REQ-031 A shared package SHALL hold the e_cmd encodings, md_op encodings, the state enum and the default MUL_LAT/DIV_LAT values.
REQ-032 One sub-module, md_lat_counter (load, decrement, zero flag), SHALL be used; all other logic is flat.

Verification
REQ-033 MULT with rs=7, rt=-3 -> md_start for 1 cycle, md_op=01; a following MFLO stalls 4 cycles and then returns mf_data=-21 (32'hFFFFFFEB), with stall_cnt=4.
REQ-034 DIVU with rs=100, rt=7, then MFHI -> 9 stall cycles, then mf_data=2; an MFLO on the next cycle -> mf_data=14 with no stall.
REQ-035 Back-to-back MULTU then DIV -> DIV is held 4 cycles, issues once, and md_start totals exactly 2 pulses.
REQ-036 MTHI rs=32'h1234 while idle -> md_mthi pulses 1 cycle; MFHI on the next cycle -> 32'h1234.
REQ-037 reset=0 three cycles into DIV_WAIT -> state IDLE and stall=0 on the next cycle; a new MULT issues immediately.
REQ-038 e_flush=1 on a DIV -> no md_start, no stall, and the state stays IDLE.
